alu_host_seq: RTL
=================

Name: alu_host_seq

Overview:
- Host-side sequencer for the serial ALU datapath. It drives the ALU's operand bus and start strobe, and captures the two result beats returned on the ALU output bus.
- Converts a single-cycle valid/ready operation request into the ALU's beat-serial load protocol.
- Returns the results as one valid/ready response.
- Sits between the instruction/test harness and the ALU. It is the opposite end of the ALU inbus/outbus interface.

Parameters:
- BEAT_GAP, 1: idle cycles between the alu_begin pulse and operand beat 0 (range 0..3).
- TIMEOUT, 64: maximum cycles from the alu_begin pulse to the Q result strobe before the operation is aborted.
- W, 8: datapath width; fixed at 8 for this ALU, kept as a parameter for the testbench.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-low reset.
- req_valid  in  1  operation request valid.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req_a  in  W  add/sub: X; div: dividend high; mul: unused.
- req_b  in  W  mul: multiplier; div: dividend low; add/sub: unused.
- req_c  in  W  add/sub: Y; mul: multiplicand; div: divisor.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_hi  out  W  A-register result (sum/difference, product high, remainder).
- rsp_lo  out  W  Q-register result (product low, quotient; don't-care for add/sub).
- rsp_err  out  1  response is a timeout abort.
- alu_op  out  2  op to the ALU; held stable from BEGIN until DONE.
- alu_begin  out  1  one-cycle start strobe to the ALU.
- alu_rst  out  1  active-high reset to the ALU; pulsed on abort.
- alu_inbus  out  W  operand bus to the ALU.
- alu_outbus  in  W  result bus from the ALU.
- alu_a_vld  in  1  ALU is driving the A result on alu_outbus this cycle.
- alu_q_vld  in  1  ALU is driving the Q result on alu_outbus this cycle.

Behaviour:
- Reset (RST=0 at a clock edge) forces these values:
  - state IDLE, req_ready=1, rsp_valid=0, rsp_hi=0, rsp_lo=0, rsp_err=0
  - alu_begin=0, alu_inbus=0, alu_op=0
  - alu_rst=1 for the reset cycle and one cycle after.
- Reset mid-operation abandons the operation and emits no response.
- States: IDLE, BEGIN, GAP, LD0, LD1, LD2, WAIT_A, WAIT_Q, ABORT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch op/a/b/c and go to BEGIN.
  - req_ready=0 in every other state, so there is no overlap between operations.
- BEGIN: alu_begin=1 for exactly one cycle. Then go to GAP if BEAT_GAP>0, else to LD0.
- GAP: count BEAT_GAP cycles with alu_inbus=0, then go to LD0.
- Operand beats, one cycle each, with alu_inbus registered:
  - LD0 drives a; for mul it drives 0.
  - LD1 drives b; for add/sub it drives 0.
  - LD2 drives c.
- After LD2, alu_inbus returns to 0 and the state goes to WAIT_A.
- WAIT_A: on alu_a_vld, capture alu_outbus into hi and go to WAIT_Q.
- WAIT_Q: on alu_q_vld, capture alu_outbus into lo and go to DONE.
- Strobes outside their wait state are ignored. If both strobes are high in the same cycle in WAIT_A, capture hi only and stay in WAIT_Q; lo is captured on a later strobe.
- Timeout:
  - The watchdog counter starts at 0 in BEGIN and increments every cycle through WAIT_Q.
  - When it reaches TIMEOUT-1 without a Q capture, go to ABORT.
- ABORT:
  - alu_rst=1 for 2 cycles.
  - Then DONE with rsp_err=1, rsp_hi=0, rsp_lo=0.
- DONE:
  - rsp_valid=1 and the response fields are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, rsp_valid drops next cycle and the state returns to IDLE.
  - A new request can be accepted the cycle after that, giving one bubble.
- Latency for a non-timeout operation is 1 (accept) + 1 (BEGIN) + BEAT_GAP + 3 (LD0..LD2) cycles, plus the ALU time to the strobes, plus 1 cycle to rsp_valid.
- alu_op is driven from the latched op during BEGIN..DONE and is 0 in IDLE.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - state enum for alu_host_seq
  - ALU_W=8.
- One sub-module, alu_host_wdog: loadable up-counter with a terminal-count flag, used for the TIMEOUT watchdog and the BEAT_GAP count.

Test Plan:
- Add: op=00, a=8'h05, c=8'h03, ALU model returns 8'h08 on alu_a_vld then alu_q_vld. Required: rsp_hi=8'h08, rsp_err=0, and beats on alu_inbus are 05,00,03.
- Mul: op=10, b=8'h0C, c=8'h0D. Required: beats 00,0C,0D; rsp_hi=8'h00, rsp_lo=8'h9C.
- Div: op=11, a=8'h00, b=8'h64, c=8'h07. Required: rsp_hi=8'h02 (remainder), rsp_lo=8'h0E (quotient).
- Backpressure: hold rsp_ready=0 for 10 cycles after DONE. Required: rsp_* stays stable, req_ready=0, and a second req_valid is not accepted until 1 cycle after the handshake.
- Timeout: no alu_q_vld, TIMEOUT=64. Required: alu_rst high for 2 cycles at cycle 64 after begin, then rsp_err=1, rsp_hi=0, rsp_lo=0.
- Reset mid-op: RST=0 during LD1. Required: next cycle state IDLE, req_ready=1, alu_inbus=0, no rsp_valid pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU host sequencer: op codes, FSM states
// and a small operand-beat helper.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BEGIN,
    ST_GAP,
    ST_LD0,
    ST_LD1,
    ST_LD2,
    ST_WAIT_A,
    ST_WAIT_Q,
    ST_ABORT,
    ST_DONE
  } seq_state_e;

  // Add and subtract take only X and Y, so their middle beat is zeroed.
  function automatic logic op_is_addsub(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_host_wdog.sv
// Loadable up-counter with a terminal-count flag. Used both as the operation
// watchdog and as the idle-gap counter between the start strobe and beat 0.
module alu_host_wdog #(
  parameter int CW = 7
) (
  input  logic          clk_i,
  input  logic          srst_n_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  input  logic [CW-1:0] last_i,
  output logic          tc_o
);

  logic [CW-1:0] count_q;

  // Load wins over counting so a new operation always restarts cleanly.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == last_i);

endmodule

// File: rtl/alu_host_seq.sv
// Host-side sequencer for the beat-serial ALU: turns one valid/ready request
// into start strobe + three operand beats, collects the A and Q result beats
// and hands them back as a single valid/ready response. A watchdog aborts
// (and resets the ALU) if the Q result never arrives.
module alu_host_seq
  import alu_pkg::*;
#(
  parameter int BEAT_GAP = 1,
  parameter int TIMEOUT  = 64,
  parameter int W        = ALU_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [W-1:0] req_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_hi,
  output logic [W-1:0] rsp_lo,
  output logic         rsp_err,
  output logic [1:0]   alu_op,
  output logic         alu_begin,
  output logic         alu_rst,
  output logic [W-1:0] alu_inbus,
  input  logic [W-1:0] alu_outbus,
  input  logic         alu_a_vld,
  input  logic         alu_q_vld
);

  localparam int             WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [1:0]     GAP_LAST = (BEAT_GAP > 0) ? 2'(BEAT_GAP - 1) : 2'd0;

  seq_state_e   state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [W-1:0] inbus_q, inbus_d;
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic         err_q, err_d;
  logic         abort_q, abort_d;
  logic [1:0]   rst_sr_q;

  logic wd_en, wd_tc, gap_tc;

  // Watchdog runs from the start strobe until the Q result is captured.
  assign wd_en = (state_q == ST_BEGIN) || (state_q == ST_GAP) ||
                 (state_q == ST_LD0)   || (state_q == ST_LD1) ||
                 (state_q == ST_LD2)   || (state_q == ST_WAIT_A) ||
                 (state_q == ST_WAIT_Q);

  alu_host_wdog #(.CW(WD_W)) u_wdog (
    .clk_i      (CLK),
    .srst_n_i   (RST),
    .load_i     (state_q == ST_IDLE),
    .load_val_i ('0),
    .en_i       (wd_en),
    .last_i     (WD_LAST),
    .tc_o       (wd_tc)
  );

  alu_host_wdog #(.CW(2)) u_gap (
    .clk_i      (CLK),
    .srst_n_i   (RST),
    .load_i     (state_q == ST_BEGIN),
    .load_val_i (2'd0),
    .en_i       (state_q == ST_GAP),
    .last_i     (GAP_LAST),
    .tc_o       (gap_tc)
  );

  // Next-state, operand latch, result capture and registered bus value.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    abort_d = abort_q;
    inbus_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          c_d     = req_c;
          hi_d    = '0;
          lo_d    = '0;
          err_d   = 1'b0;
          state_d = ST_BEGIN;
        end
      end
      ST_BEGIN:  state_d = (BEAT_GAP > 0) ? ST_GAP : ST_LD0;
      ST_GAP:    if (gap_tc) state_d = ST_LD0;
      ST_LD0:    state_d = ST_LD1;
      ST_LD1:    state_d = ST_LD2;
      ST_LD2:    state_d = ST_WAIT_A;
      ST_WAIT_A: begin
        // A simultaneous Q strobe is deliberately dropped; Q must come later.
        if (alu_a_vld) begin
          hi_d    = alu_outbus;
          state_d = ST_WAIT_Q;
        end
      end
      ST_WAIT_Q: begin
        if (alu_q_vld) begin
          lo_d    = alu_outbus;
          state_d = ST_DONE;
        end
      end
      ST_ABORT: begin
        abort_d = 1'b1;
        if (abort_q) state_d = ST_DONE;
      end
      ST_DONE:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A Q capture in the terminal cycle still counts as a completed operation.
    if (wd_en && wd_tc && !((state_q == ST_WAIT_Q) && alu_q_vld)) begin
      state_d = ST_ABORT;
      abort_d = 1'b0;
      hi_d    = '0;
      lo_d    = '0;
      err_d   = 1'b1;
    end

    // Bus value is chosen from the upcoming state so it is registered per beat.
    unique case (state_d)
      ST_LD0:  inbus_d = (op_d == OP_MUL) ? '0 : a_d;
      ST_LD1:  inbus_d = op_is_addsub(op_d) ? '0 : b_d;
      ST_LD2:  inbus_d = c_d;
      default: inbus_d = '0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      inbus_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      inbus_q <= inbus_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // Stretch the ALU reset one cycle past our own reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rst_sr_q <= 2'b11;
    end else begin
      rst_sr_q <= {rst_sr_q[0], 1'b0};
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_err   = err_q;
  assign alu_begin = (state_q == ST_BEGIN);
  assign alu_op    = (state_q == ST_IDLE) ? 2'b00 : op_q;
  assign alu_rst   = rst_sr_q[1] | (state_q == ST_ABORT);
  assign alu_inbus = inbus_q;

endmodule
